// File: rtl/ecg_pkg.sv
// Shared types and default sizing for the ECG sample write path.
package ecg_pkg;

    localparam int unsigned ECG_DATA_W    = 16;
    localparam int unsigned ECG_ADDR_W    = 12;
    localparam int unsigned ECG_FRAME_LEN = 4096;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WAIT_BANK
    } wr_state_t;

endpackage

// File: rtl/wr_bank_ctrl.sv
// Ping-pong bank ownership: tracks which banks the reader holds and which bank is being filled.
module wr_bank_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_complete,
    input  logic       i_release,
    input  logic       i_rel_bank,
    output logic       o_cur_bank,
    output logic [1:0] o_bank_full,
    output logic       o_next_bank_busy
);

    logic [1:0] r_full;
    logic       r_cur_bank;
    logic [1:0] w_rel_mask;
    logic [1:0] w_set_mask;
    logic [1:0] w_full_rel;
    logic       w_other_bank;

    // Release is applied before the completion set, so a bank freed this cycle is seen as free.
    assign w_rel_mask       = i_release  ? (2'b01 << i_rel_bank) : '0;
    assign w_set_mask       = i_complete ? (2'b01 << r_cur_bank) : '0;
    assign w_full_rel       = r_full & ~w_rel_mask;
    assign w_other_bank     = ~r_cur_bank;
    assign o_next_bank_busy = w_full_rel[w_other_bank];
    assign o_cur_bank       = r_cur_bank;
    assign o_bank_full      = r_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full     <= '0;
            r_cur_bank <= 1'b0;
        end else begin
            r_full <= w_full_rel | w_set_mask;
            if (i_complete) begin
                r_cur_bank <= ~r_cur_bank;
            end
        end
    end

endmodule

// File: rtl/ecg_sample_writer.sv
// ECG sample writer: streams samples into a two-bank BRAM, one frame per bank.
// Optional frame total output enabled by defining FRAME_SUM_EN.
module ecg_sample_writer
    import ecg_pkg::*;
#(
    parameter int unsigned DATA_W    = ECG_DATA_W,
    parameter int unsigned ADDR_W    = ECG_ADDR_W,
    parameter int unsigned FRAME_LEN = ECG_FRAME_LEN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    input  logic              bank_release,
    input  logic              rel_bank,
    output logic              wr_en,
    output logic              wr_bank,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              frame_done,
    output logic              frame_bank,
    output logic [1:0]        bank_full
`ifdef FRAME_SUM_EN
    ,output logic [DATA_W+ADDR_W-1:0] frame_sum
`endif
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

    wr_state_t         r_state;
    wr_state_t         w_state_nxt;
    logic              r_s_ready;
    logic [ADDR_W-1:0] r_addr;
    logic              r_wr_en;
    logic              r_wr_bank;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_frame_done;
    logic              r_frame_bank;

    logic              w_accept;
    logic              w_last;
    logic              w_cur_bank;
    logic              w_next_bank_busy;
    logic [1:0]        w_bank_full;

    assign w_accept = s_valid & r_s_ready;
    assign w_last   = w_accept & (r_addr == LAST_ADDR);

    wr_bank_ctrl u_bank_ctrl (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_complete       (w_last),
        .i_release        (bank_release),
        .i_rel_bank       (rel_bank),
        .o_cur_bank       (w_cur_bank),
        .o_bank_full      (w_bank_full),
        .o_next_bank_busy (w_next_bank_busy)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = FILL;
                end
            end
            FILL: begin
                if (w_last && w_next_bank_busy) begin
                    w_state_nxt = WAIT_BANK;
                end
            end
            WAIT_BANK: begin
                if (bank_release && (rel_bank == w_cur_bank)) begin
                    w_state_nxt = FILL;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // s_ready is registered from the next state so it tracks FILL with no combinational path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_s_ready <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_s_ready <= (w_state_nxt == FILL);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
        end else if (w_accept) begin
            r_addr <= w_last ? '0 : r_addr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_en      <= 1'b0;
            r_wr_bank    <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_frame_done <= 1'b0;
            r_frame_bank <= 1'b0;
        end else begin
            r_wr_en      <= w_accept;
            r_frame_done <= w_last;
            if (w_accept) begin
                r_wr_bank <= w_cur_bank;
                r_wr_addr <= r_addr;
                r_wr_data <= s_data;
            end
            if (w_last) begin
                r_frame_bank <= w_cur_bank;
            end
        end
    end

`ifdef FRAME_SUM_EN
    logic [DATA_W+ADDR_W-1:0] r_acc;
    logic [DATA_W+ADDR_W-1:0] r_frame_sum;
    logic [DATA_W+ADDR_W-1:0] w_acc_nxt;

    assign w_acc_nxt = r_acc + (DATA_W+ADDR_W)'(s_data);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_frame_sum <= '0;
        end else if (w_accept) begin
            if (w_last) begin
                r_frame_sum <= w_acc_nxt;
                r_acc       <= '0;
            end else begin
                r_acc <= w_acc_nxt;
            end
        end
    end

    assign frame_sum = r_frame_sum;
`endif

    assign s_ready    = r_s_ready;
    assign wr_en      = r_wr_en;
    assign wr_bank    = r_wr_bank;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign frame_done = r_frame_done;
    assign frame_bank = r_frame_bank;
    assign bank_full  = w_bank_full;

endmodule

// File: tb/tb_ecg_sample_writer.sv
// Directed scoreboard bench for ecg_sample_writer with an 8-sample frame.
module tb_ecg_sample_writer;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 12;
    localparam int unsigned FL = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_ready;
    logic          bank_release = 1'b0;
    logic          rel_bank = 1'b0;
    logic          wr_en;
    logic          wr_bank;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          frame_done;
    logic          frame_bank;
    logic [1:0]    bank_full;
`ifdef FRAME_SUM_EN
    logic [DW+AW-1:0] frame_sum;
`endif

    ecg_sample_writer #(.DATA_W(DW), .ADDR_W(AW), .FRAME_LEN(FL)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .bank_release (bank_release),
        .rel_bank     (rel_bank),
        .wr_en        (wr_en),
        .wr_bank      (wr_bank),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .frame_done   (frame_done),
        .frame_bank   (frame_bank),
        .bank_full    (bank_full)
`ifdef FRAME_SUM_EN
        ,.frame_sum   (frame_sum)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          bank;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          done;
    } exp_t;

    exp_t          exp_q[$];
    int unsigned   n_pass = 0;
    int unsigned   n_chk  = 0;
    logic          m_bank = 1'b0;
    logic [AW-1:0] m_addr = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Scoreboard consumer: every DUT write must match the oldest accepted sample.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 64'(wr_addr), 64'hFFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("wr_bank", 64'(wr_bank), 64'(e.bank));
                    chk("wr_addr", 64'(wr_addr), 64'(e.addr));
                    chk("wr_data", 64'(wr_data), 64'(e.data));
                    chk("frame_done", 64'(frame_done), 64'(e.done));
                    if (e.done) chk("frame_bank", 64'(frame_bank), 64'(e.bank));
                end
            end else if (frame_done) begin
                chk("frame_done_without_write", 64'(frame_done), 64'd0);
            end
        end
    end

    // Called at a negedge; waits for s_ready, queues the expected write, returns at the next negedge.
    task automatic send(input logic [DW-1:0] d, input bit rel, input logic relb);
        int unsigned n = 0;
        s_valid = 1'b1;
        s_data  = d;
        while (!s_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) begin
            chk("send_timeout", 64'd0, 64'd1);
            s_valid = 1'b0;
            return;
        end
        if (rel) begin
            bank_release = 1'b1;
            rel_bank     = relb;
        end
        exp_q.push_back('{bank: m_bank, addr: m_addr, data: d, done: (m_addr == AW'(FL - 1))});
        if (m_addr == AW'(FL - 1)) begin
            m_addr = '0;
            m_bank = ~m_bank;
        end else begin
            m_addr = m_addr + 1'b1;
        end
        @(negedge clk);
        s_valid      = 1'b0;
        bank_release = 1'b0;
    endtask

    task automatic pulse_release(input logic b);
        bank_release = 1'b1;
        rel_bank     = b;
        @(negedge clk);
        bank_release = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with start low: everything stays quiet.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("rst_s_ready", 64'(s_ready), 64'd0);
            chk("rst_outs", {31'd0, wr_en, frame_done, frame_bank, wr_bank, bank_full, wr_addr, wr_data},
                64'd0);
        end
`ifdef FRAME_SUM_EN
        chk("rst_frame_sum", 64'(frame_sum), 64'd0);
`endif

        // Single frame into bank 0.
        start = 1'b1;
        for (int i = 1; i <= 8; i++) send(DW'(i), 1'b0, 1'b0);
        @(negedge clk);
        chk("f0_bank_full", 64'(bank_full), 64'b01);
        chk("f0_s_ready", 64'(s_ready), 64'd1);
`ifdef FRAME_SUM_EN
        chk("f0_frame_sum", 64'(frame_sum), 64'd36);
`endif

        // Releasing a bank the reader does not hold changes nothing.
        pulse_release(1'b1);
        chk("spur_bank_full", 64'(bank_full), 64'b01);
        chk("spur_s_ready", 64'(s_ready), 64'd1);

        // Fill bank 1 with bank 0 still held: stall.
        for (int i = 9; i <= 16; i++) send(DW'(i), 1'b0, 1'b0);
        @(negedge clk);
        chk("bp_bank_full", 64'(bank_full), 64'b11);
        chk("bp_s_ready", 64'(s_ready), 64'd0);
`ifdef FRAME_SUM_EN
        chk("f1_frame_sum", 64'(frame_sum), 64'd100);
`endif
        repeat (3) @(negedge clk);
        chk("bp_s_ready_hold", 64'(s_ready), 64'd0);
        pulse_release(1'b0);
        chk("rel0_s_ready", 64'(s_ready), 64'd1);
        chk("rel0_bank_full", 64'(bank_full), 64'b10);

        // Bank 0 refill, stalls again on bank 1.
        for (int i = 17; i <= 24; i++) send(DW'(i), 1'b0, 1'b0);
        @(negedge clk);
        chk("bp2_bank_full", 64'(bank_full), 64'b11);
        chk("bp2_s_ready", 64'(s_ready), 64'd0);
        pulse_release(1'b1);
        chk("rel1_s_ready", 64'(s_ready), 64'd1);

        // Complete bank 1 in the same cycle bank 0 is released: no stall.
        for (int i = 25; i <= 31; i++) send(DW'(i), 1'b0, 1'b0);
        send(DW'(32), 1'b1, 1'b0);
        chk("sim_s_ready", 64'(s_ready), 64'd1);
        chk("sim_bank_full", 64'(bank_full), 64'b10);
`ifdef FRAME_SUM_EN
        chk("f3_frame_sum", 64'(frame_sum), 64'd228);
`endif
        send(DW'(33), 1'b0, 1'b0);

        // Mid-frame asynchronous reset after 5 of 8 samples.
        for (int i = 34; i <= 37; i++) send(DW'(i), 1'b0, 1'b0);
        @(negedge clk);
        chk("pre_rst_queue", 64'(exp_q.size()), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", {30'd0, s_ready, wr_en, frame_done, frame_bank, wr_bank, bank_full, wr_addr, wr_data},
            64'd0);
        m_bank = 1'b0;
        m_addr = '0;
        @(negedge clk);
        rst_n = 1'b1;
        send(16'hABCD, 1'b0, 1'b0);
        @(negedge clk);
        chk("post_rst_bank_full", 64'(bank_full), 64'b00);
        chk("final_queue", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
